serial_adder_arbiter: RTL and testbench
=======================================

// Module: serial_adder_arbiter
// PURPOSE
//  Shares one bit-serial full adder (1-bit sum, 1-bit carry register) between two requesters.
//  Round-robin arbiter accepts an N-bit operand pair and feeds it through the adder LSB first.
//  Collects the N sum bits and the final carry, then returns the result with the requester ID.
//  Sits between operand producers and the result consumer.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>= 2)
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst         in   1      reset, asynchronous, active-low (0 = reset)
//  req0_valid  in   1      requester 0 has an operand pair
//  req0_a      in   WIDTH  requester 0 operand a
//  req0_b      in   WIDTH  requester 0 operand b
//  req0_ready  out  1      requester 0 handshake accepted this cycle
//  req1_valid  in   1      requester 1 has an operand pair
//  req1_a      in   WIDTH  requester 1 operand a
//  req1_b      in   WIDTH  requester 1 operand b
//  req1_ready  out  1      requester 1 handshake accepted this cycle
//  res_valid   out  1      result available
//  res_sum     out  WIDTH  (a + b) mod 2^WIDTH
//  res_carry   out  1      carry out of bit WIDTH-1
//  res_id      out  1      requester that owns the result
//  res_ready   in   1      consumer takes the result
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; res_valid=0, res_sum=0, res_carry=0, res_id=0; carry reg=0; bit counter=0.
//   - RR pointer favours req0.
//   - Reset mid-operation aborts the operation; no result is produced.
//  FSM states: IDLE -> ADD -> DONE -> IDLE.
//  IDLE:
//   - grant = the only valid requester.
//   - If both are valid, grant = the requester the RR pointer favours.
//   - reqX_ready = (state==IDLE) && grant==X; this is combinational from the valids.
//   - On valid&ready: latch a, b and ID; clear carry and counter; go to ADD.
//  ADD, one bit per cycle:
//   - s = a0^b0^c.
//   - c_next = (a0&b0)|(a0&c)|(b0&c).
//   - Only ^ & | ~ are used in the adder.
//   - a and b shift right; s shifts into the MSB of the sum register.
//   - Counter increments. After the WIDTH-th bit: res_carry=c_next, go to DONE.
//  DONE:
//   - res_valid=1; res_sum, res_carry and res_id are held stable until res_ready=1.
//   - On res_valid&res_ready: res_valid drops next cycle; go to IDLE.
//   - RR pointer then favours the other requester (the one not just served).
//  Latency and throughput:
//   - Handshake in cycle t gives res_valid in cycle t+WIDTH+1.
//   - Best case is WIDTH+2 cycles per operation.
//  Interface rules:
//   - reqX_ready=0 in ADD and DONE.
//   - Requesters hold valid and data stable until ready. Dropping valid early is legal and simply means no grant.
//   - Simultaneous res_ready and a new reqX_valid in DONE: the new request is accepted only in the following IDLE cycle.
//   - Wrap-around: sum is truncated to WIDTH bits; overflow is reported only on res_carry.
// TESTING
//  1. req0 a=0x3C b=0x05, res_ready=1 -> res_sum=0x41, carry=0, id=0, res_valid exactly 9 cycles after the handshake.
//  2. req1 a=0xFF b=0x01 -> res_sum=0x00, carry=1, id=1. Also 0xFF+0xFF -> 0xFE, carry=1.
//  3. Both valid from reset, held -> grants alternate 0,1,0,1. Sums 0x10+0x20=0x30 (id 0) and 0x01+0x02=0x03 (id 1).
//  4. res_ready=0 for 5 cycles in DONE -> res_valid/sum/id stable, both reqX_ready=0. Release -> IDLE next cycle.
//  5. rst=0 at ADD bit 3 -> res_valid=0 immediately (async). After release, 0x0A+0x0B -> 0x15 and req0 wins a tie.
//  6. 1000 random pairs with random valids and res_ready -> each result matches {carry,sum}=a+b, correct id, no loss or duplication.

Source files
------------

// File: rtl/serial_adder_arbiter_if.sv
// ============================================================================
// Module  : serial_adder_arbiter_if
// Brief   : Two-requester operand bus plus result bus for serial_adder_arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_arbiter_if #(
    parameter int WIDTH = 8
) ();

    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_id;
    logic             res_ready;

    // Producer/consumer side
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_sum, res_carry, res_id,
        output res_ready
    );

    // Adder side
    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_sum, res_carry, res_id,
        input  res_ready
    );

endinterface

`default_nettype wire

// File: rtl/serial_adder_arbiter.sv
// ============================================================================
// Module  : serial_adder_arbiter
// Brief   : Round-robin shared bit-serial adder, LSB first, one bit per cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_adder_arbiter_if.slave  bus
);

    localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_rr_ptr;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_res_valid;
    logic               r_res_carry;
    logic               r_res_id;

    logic               w_grant;
    logic               w_accept;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_last_bit;
    logic               w_res_take;
    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    // Full adder restricted to plain gate operators
    assign w_sum_bit    = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_carry_next = (r_op_a[0] & r_op_b[0]) |
                          (r_op_a[0] & r_carry)   |
                          (r_op_b[0] & r_carry);

    assign w_last_bit = (r_cnt == LAST_BIT);
    assign w_res_take = r_res_valid & bus.res_ready;
    assign w_sel_a    = w_grant ? bus.req1_a : bus.req0_a;
    assign w_sel_b    = w_grant ? bus.req1_b : bus.req0_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_accept     = 1'b0;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A tie goes to the pointer; a lone requester always wins.
                if (bus.req0_valid && bus.req1_valid) begin
                    w_grant = r_rr_ptr;
                end else begin
                    w_grant = bus.req1_valid;
                end
                w_ready0 = bus.req0_valid & ~w_grant;
                w_ready1 = bus.req1_valid &  w_grant;
                w_accept = w_ready0 | w_ready1;
                if (w_accept) begin
                    w_next_state = ST_ADD;
                end
            end
            ST_ADD: begin
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_res_take) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_carry <= 1'b0;
            r_res_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_res_id <= w_grant;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_ADD: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 last.
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (w_last_bit) begin
                        r_res_carry <= w_carry_next;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_res_take) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= ~r_res_id;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_sum    = r_sum;
    assign bus.res_carry  = r_res_carry;
    assign bus.res_id     = r_res_id;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_arbiter.sv
// Scoreboard bench for serial_adder_arbiter: directed cases then random traffic,
// checked against an arithmetic reference with a round-robin arbitration model.
`default_nettype none

module tb_serial_adder_arbiter;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_arbiter_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             id;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    bit   busy   = 1'b0;
    bit   ptr    = 1'b0;
    int   hs_cyc = 0;
    bit   rand_on;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic id);
        exp_t             e;
        logic [WIDTH:0]   s;
        s       = {1'b0, a} + {1'b0, b};
        e.sum   = s[WIDTH-1:0];
        e.carry = s[WIDTH];
        e.id    = id;
        return e;
    endfunction

    // Monitor: samples mid-cycle, checks readies, result timing and content.
    always @(negedge clk) begin
        logic e0, e1, ev;
        exp_t f;
        if (!rst) begin
            q.delete();
            busy = 1'b0;
            ptr  = 1'b0;
        end else begin
            e0 = !busy && bus.req0_valid && (!bus.req1_valid || ptr == 1'b0);
            e1 = !busy && bus.req1_valid && (!bus.req0_valid || ptr == 1'b1);
            ev = busy && ((cyc - hs_cyc) >= WIDTH + 1);
            chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
            chk("res_valid",  32'(bus.res_valid),  32'(ev));
            if (bus.res_valid) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    f = q[0];
                    chk("res_sum",   32'(bus.res_sum),   32'(f.sum));
                    chk("res_carry", 32'(bus.res_carry), 32'(f.carry));
                    chk("res_id",    32'(bus.res_id),    32'(f.id));
                    if (bus.res_ready) begin
                        void'(q.pop_front());
                        busy = 1'b0;
                        ptr  = ~f.id;
                    end
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                q.push_back(model(bus.req0_a, bus.req0_b, 1'b0));
                busy   = 1'b1;
                hs_cyc = cyc;
            end else if (bus.req1_valid && bus.req1_ready) begin
                q.push_back(model(bus.req1_a, bus.req1_b, 1'b1));
                busy   = 1'b1;
                hs_cyc = cyc;
            end
        end
    end

    task automatic send(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n   = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        while (!got && n < 300) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
            else n++;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_sum",   32'(bus.res_sum),   32'd0);
        chk("rst_res_carry", 32'(bus.res_carry), 32'd0);
        chk("rst_res_id",    32'(bus.res_id),    32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst            = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Basic adds and wrap-around
        send(1'b0, 8'h3C, 8'h05);
        drain();
        send(1'b1, 8'hFF, 8'h01);
        send(1'b1, 8'hFF, 8'hFF);
        send(1'b0, 8'h00, 8'h00);
        drain();

        // Both requesters held valid from reset: grants alternate
        reset_pulse();
        fork
            begin send(1'b0, 8'h10, 8'h20); send(1'b0, 8'h10, 8'h20); end
            begin send(1'b1, 8'h01, 8'h02); send(1'b1, 8'h01, 8'h02); end
        join
        drain();

        // Consumer stalls in DONE while the other requester waits
        bus.res_ready = 1'b0;
        fork
            send(1'b0, 8'h5A, 8'hC3);
            begin repeat (2) @(posedge clk); send(1'b1, 8'h11, 8'h22); end
            begin
                n = 0;
                while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
                repeat (5) @(posedge clk);
                #1;
                bus.res_ready = 1'b1;
            end
        join
        drain();

        // Abort mid-add, then a tie after reset goes to req0
        send(1'b1, 8'h77, 8'h99);
        repeat (3) @(posedge clk);
        #2;
        reset_pulse();
        fork
            send(1'b0, 8'h0A, 8'h0B);
            send(1'b1, 8'h40, 8'h40);
        join
        drain();

        // Random traffic
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) bus.res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        fork
            begin
                repeat (500) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    send(1'b0, WIDTH'($urandom), WIDTH'($urandom));
                end
            end
            begin
                repeat (500) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    send(1'b1, WIDTH'($urandom), WIDTH'($urandom));
                end
            end
        join
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        drain();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
